// File: rtl/instr_decode_queue_pkg.sv
// Shared MIPS-32 field positions, immediate-form opcodes and the immediate extension helper
// used by instr_decode_queue (the helper is only referenced when IMM_EXT_EN is defined).
package instr_decode_queue_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int INDEX_MSB  = 25;
  localparam int INDEX_LSB  = 0;

  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_UPPER
  } imm_ext_kind_e;

  // Logical immediates are unsigned, LUI places the immediate in the upper half.
  function automatic imm_ext_kind_e imm_ext_kind(input logic [5:0] op);
    imm_ext_kind_e kind;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: kind = EXT_ZERO;
      OP_LUI:                   kind = EXT_UPPER;
      default:                  kind = EXT_SIGN;
    endcase
    return kind;
  endfunction

  function automatic logic [31:0] imm_extend(input logic [5:0] op, input logic [15:0] imm);
    logic [31:0] ext;
    case (imm_ext_kind(op))
      EXT_ZERO:  ext = {16'h0000, imm};
      EXT_UPPER: ext = {imm, 16'h0000};
      default:   ext = {{16{imm[15]}}, imm};
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/instr_decode_queue_mem.sv
// Entry storage for the decode queue: DEPTH x W register file, one write port, one async read.
// Contents are deliberately not reset; validity is tracked by the pointers in the top.
module instr_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered fetch-to-decode queue that slices the head entry into MIPS-32 fields.
// Optional macro IMM_EXT_EN adds the imm_ext output (opcode-dependent extended immediate).
module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        immediate,
  output logic [25:0]        instr_index,
`ifdef IMM_EXT_EN
  output logic [31:0]        imm_ext,
`endif
  output logic [CW-1:0]      count
);

  localparam int AW = CW - 1;
  localparam int EW = PC_W + INSTR_W;

  logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full, empty, push, pop;
  logic [EW-1:0]      head_entry;
  logic [INSTR_W-1:0] head_instr;

  // Full/empty come from registered pointers only, so in_ready never sees out_ready.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full && !flush;
  assign pop       = out_ready && !empty && !flush;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (head_entry)
  );

  // Stale storage must never leak out, so the head is zeroed while empty.
  assign head_instr  = empty ? '0 : head_entry[INSTR_W-1:0];
  assign out_pc      = empty ? '0 : head_entry[EW-1:INSTR_W];
  assign out_instr   = head_instr;
  assign opcode      = head_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs          = head_instr[RS_MSB:RS_LSB];
  assign rt          = head_instr[RT_MSB:RT_LSB];
  assign rd          = head_instr[RD_MSB:RD_LSB];
  assign shamt       = head_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct       = head_instr[FUNCT_MSB:FUNCT_LSB];
  assign immediate   = head_instr[IMM_MSB:IMM_LSB];
  assign instr_index = head_instr[INDEX_MSB:INDEX_LSB];

`ifdef IMM_EXT_EN
  assign imm_ext = empty ? 32'h0 : imm_extend(opcode, immediate);
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: a model queue predicts handshakes, count and head fields.
// Define IMM_EXT_EN to also check the extended immediate.
module tb_instr_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] instr_index;
  logic [2:0]  count;
`ifdef IMM_EXT_EN
  logic [31:0] imm_ext;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  instr_decode_queue #(
    .INSTR_W (32),
    .PC_W    (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .immediate   (immediate),
    .instr_index (instr_index),
`ifdef IMM_EXT_EN
    .imm_ext     (imm_ext),
`endif
    .count       (count)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's predicted state and head entry.
  task automatic checkOutput();
    logic [63:0] e;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ex;
    e  = (sb.size() != 0) ? sb[0] : 64'h0;
    ep = e[63:32];
    ei = e[31:0];
    checkValue("in_ready",    64'(in_ready),    64'(sb.size() < DEPTH));
    checkValue("out_valid",   64'(out_valid),   64'(sb.size() != 0));
    checkValue("count",       64'(count),       64'(sb.size()));
    checkValue("out_instr",   64'(out_instr),   64'(ei));
    checkValue("out_pc",      64'(out_pc),      64'(ep));
    checkValue("opcode",      64'(opcode),      64'(ei[31:26]));
    checkValue("rs",          64'(rs),          64'(ei[25:21]));
    checkValue("rt",          64'(rt),          64'(ei[20:16]));
    checkValue("rd",          64'(rd),          64'(ei[15:11]));
    checkValue("shamt",       64'(shamt),       64'(ei[10:6]));
    checkValue("funct",       64'(funct),       64'(ei[5:0]));
    checkValue("immediate",   64'(immediate),   64'(ei[15:0]));
    checkValue("instr_index", 64'(instr_index), 64'(ei[25:0]));
    if (ei[31:26] inside {6'h0c, 6'h0d, 6'h0e}) ex = {16'h0, ei[15:0]};
    else if (ei[31:26] == 6'h0f)                ex = {ei[15:0], 16'h0};
    else                                         ex = {{16{ei[15]}}, ei[15:0]};
`ifdef IMM_EXT_EN
    checkValue("imm_ext", 64'(imm_ext), 64'(ex));
`endif
  endtask

  // One clock of stimulus: check pre-edge outputs, advance the model, step to the next negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    logic acc;
    logic pp;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    acc = v && (sb.size() < DEPTH) && !fl;
    pp  = ordy && (sb.size() != 0) && !fl;
    if (fl) sb.delete();
    else begin
      if (pp)  void'(sb.pop_front());
      if (acc) sb.push_back({pc, instr});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput();
    reset = 1'b0;

    applyStimulus(1'b1, 32'h8C22_0004, 32'h0000_3000, 1'b0, 1'b0);
    checkValue("t2_out_valid", 64'(out_valid), 64'h1);
    checkValue("t2_opcode",    64'(opcode),    64'h23);
    checkValue("t2_rs",        64'(rs),        64'h1);
    checkValue("t2_rt",        64'(rt),        64'h2);
    checkValue("t2_imm",       64'(immediate), 64'h0004);
    checkValue("t2_pc",        64'(out_pc),    64'h3000);

    for (int i = 1; i < 4; i++)
      applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 32'h0000_3000 + 32'(4 * i), 1'b0, 1'b0);
    checkValue("t3_full_count", 64'(count),    64'h4);
    checkValue("t3_full_ready", 64'(in_ready), 64'h0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_4000, 1'b0, 1'b0);
    checkValue("t3_refused_count", 64'(count), 64'h4);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_4004, 1'b1, 1'b0);
    checkValue("t3_ready_after_pop", 64'(in_ready), 64'h1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 32'h0123_4000 + 32'(i * 32'h41), 32'h0000_5000 + 32'(4 * i), 1'b1, 1'b0);
    checkValue("t3_wrap_count", 64'(count), 64'h3);

    applyStimulus(1'b1, 32'hCAFE_0001, 32'h0000_6000, 1'b1, 1'b1);
    checkValue("t4_flush_count", 64'(count),     64'h0);
    checkValue("t4_flush_valid", 64'(out_valid), 64'h0);

    applyStimulus(1'b1, 32'h0000_0020, 32'h0000_7000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0085_1822, 32'h0000_7004, 1'b1, 1'b0);
    checkValue("t5_count", 64'(count),     64'h1);
    checkValue("t5_head",  64'(out_instr), 64'h0085_1822);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h3422_8000, 32'h0000_8000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2022_8000, 32'h0000_8004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3C01_1234, 32'h0000_8008, 1'b0, 1'b0);
`ifdef IMM_EXT_EN
    checkValue("t6_ori", 64'(imm_ext), 64'h0000_8000);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IMM_EXT_EN
    checkValue("t6_addi", 64'(imm_ext), 64'hFFFF_8000);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IMM_EXT_EN
    checkValue("t6_lui", 64'(imm_ext), 64'h1234_0000);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h1111_2222; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
